conv_pe_spad: RTL and testbench

// Sequential, parametrised convolution PE with a local weight scratchpad (SPAD).

---
 rtl/conv_pe_spad.sv | 117 +++++++++++
 tb/tb_conv_pe_spad.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_spad.sv
// Convolution PE with a local weight scratchpad: loads one kernel row, then
// streams KERNEL_SIZE activations per window and emits inpsum + dot(window, kernel).
module conv_pe_spad #(
    parameter int unsigned WEIGHT_W    = 2,
    parameter int unsigned ACT_W       = 2,
    parameter int unsigned PSUM_W      = 32,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wt_valid,
    output logic                wt_ready,
    input  logic [WEIGHT_W-1:0] wt_data,
    input  logic                wt_reload,
    input  logic                act_valid,
    output logic                act_ready,
    input  logic [ACT_W-1:0]    act_data,
    input  logic [PSUM_W-1:0]   inpsum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PSUM_W-1:0]   outpsum,
    output logic [CNT_W-1:0]    gated_cnt
);

    localparam int unsigned IDX_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int unsigned PROD_W = WEIGHT_W + ACT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [WEIGHT_W-1:0]   spad [KERNEL_SIZE];
    logic [PSUM_W-1:0]     acc;

    logic                  act_nz;
    logic                  idx_zero;
    logic                  acc_we;
    logic [WEIGHT_W-1:0]   mul_w;
    logic [ACT_W-1:0]      mul_a;
    logic signed [PROD_W-1:0] prod;
    logic [PSUM_W-1:0]     prod_ext;
    logic [PSUM_W-1:0]     acc_sum;

    // Handshake readiness follows the state register; reload blocks tap 0 only.
    assign idx_zero  = (idx == '0);
    assign wt_ready  = (state == LOAD);
    assign act_ready = (state == ACCUM) && !(idx_zero && wt_reload);
    assign out_valid = (state == DRAIN);

    // Zero activations hold both multiplier operands at zero.
    assign act_nz   = |act_data;
    assign mul_w    = act_nz ? spad[idx] : '0;
    assign mul_a    = act_nz ? act_data  : '0;
    assign prod     = PROD_W'($signed(mul_w)) * PROD_W'($signed(mul_a));
    assign prod_ext = PSUM_W'(prod);
    assign acc_sum  = (idx_zero ? inpsum : acc) + prod_ext;
    assign acc_we   = idx_zero || act_nz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            idx       <= '0;
            acc       <= '0;
            outpsum   <= '0;
            gated_cnt <= '0;
            for (int i = 0; i < int'(KERNEL_SIZE); i++) begin
                spad[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (wt_valid) begin
                        spad[idx] <= wt_data;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ACCUM;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (idx_zero && wt_reload) begin
                        state <= LOAD;
                    end else if (act_valid) begin
                        if (acc_we) begin
                            acc <= acc_sum;
                        end
                        if (!act_nz && (gated_cnt != '1)) begin
                            gated_cnt <= gated_cnt + CNT_W'(1);
                        end
                        if (idx == LAST_IDX) begin
                            idx     <= '0;
                            outpsum <= acc_we ? acc_sum : acc;
                            state   <= DRAIN;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state <= ACCUM;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pe_spad.sv
// Randomized scoreboard bench for conv_pe_spad; a 32-bit/16-bit-counter instance and an
// 8-bit/2-bit-counter instance share stimulus so psum wrap and counter saturation are covered.
module tb_conv_pe_spad;

    logic        clk;
    logic        reset;
    logic        wt_valid, wt_reload, act_valid, out_ready;
    logic [1:0]  wt_data, act_data;
    logic [31:0] inpsum;

    logic        wt_ready, act_ready, out_valid;
    logic [31:0] outpsum;
    logic [15:0] gated_cnt;
    logic        wt_ready8, act_ready8, out_valid8;
    logic [7:0]  outpsum8;
    logic [1:0]  gated_cnt8;

    conv_pe_spad dut (
        .clk(clk), .reset(reset),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data), .wt_reload(wt_reload),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .inpsum(inpsum),
        .out_valid(out_valid), .out_ready(out_ready), .outpsum(outpsum), .gated_cnt(gated_cnt)
    );

    conv_pe_spad #(.PSUM_W(8), .CNT_W(2)) dut8 (
        .clk(clk), .reset(reset),
        .wt_valid(wt_valid), .wt_ready(wt_ready8), .wt_data(wt_data), .wt_reload(wt_reload),
        .act_valid(act_valid), .act_ready(act_ready8), .act_data(act_data), .inpsum(inpsum[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready), .outpsum(outpsum8), .gated_cnt(gated_cnt8)
    );

    typedef struct {
        logic [31:0] p;
        int          z;
    } exp_t;

    exp_t sb[$];
    int   kw[3];
    int   zeros;
    int   checks = 0;
    int   errors = 0;
    bit   hold = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: mostly accepting, forced low while hold is set.
    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare every accepted output against the oldest expected window.
    initial begin
        exp_t e;
        int   e16, e2;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got outpsum %0h with empty scoreboard", outpsum);
                end else begin
                    e   = sb.pop_front();
                    e16 = (e.z > 65535) ? 65535 : e.z;
                    e2  = (e.z > 3) ? 3 : e.z;
                    chk("outpsum32", 64'(outpsum), 64'(e.p));
                    chk("outpsum8", 64'(outpsum8), 64'(e.p[7:0]));
                    chk("out_valid8", 64'(out_valid8), 64'(1));
                    chk("gated_cnt16", 64'(gated_cnt), 64'(e16));
                    chk("gated_cnt2", 64'(gated_cnt8), 64'(e2));
                end
            end
        end
    end

    task automatic do_reset();
        act_valid = 0;
        wt_valid  = 0;
        wt_reload = 0;
        reset     = 1;
        #2;
        chk("rst_wt_ready", 64'(wt_ready), 64'(1));
        chk("rst_act_ready", 64'(act_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_outpsum", 64'(outpsum), 64'(0));
        chk("rst_gated_cnt", 64'(gated_cnt), 64'(0));
        chk("rst_wt_ready8", 64'(wt_ready8), 64'(1));
        chk("rst_act_ready8", 64'(act_ready8), 64'(0));
        chk("rst_out_valid8", 64'(out_valid8), 64'(0));
        chk("rst_outpsum8", 64'(outpsum8), 64'(0));
        chk("rst_gated_cnt8", 64'(gated_cnt8), 64'(0));
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        kw    = '{0, 0, 0};
        zeros = 0;
        sb.delete();
    endtask

    task automatic send_wt(input int w);
        int n = 0;
        wt_valid = 1;
        wt_data  = 2'(w);
        @(negedge clk);
        while (!wt_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!wt_ready) begin
            checks++;
            errors++;
            $display("FAIL wt_timeout got wt_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        wt_valid = 0;
    endtask

    task automatic load_kernel(input int w[3]);
        for (int t = 0; t < 3; t++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            send_wt(w[t]);
        end
        kw = w;
    endtask

    task automatic send_act(input int a, input logic [31:0] ip, input bit last);
        int n = 0;
        act_valid = 1;
        act_data  = 2'(a);
        inpsum    = ip;
        @(negedge clk);
        while (!act_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!act_ready) begin
            checks++;
            errors++;
            $display("FAIL act_timeout got act_ready 0 expected 1");
        end
        if (last) chk("pre_last_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        act_valid = 0;
        act_data  = 2'($urandom);
        if (last) begin
            chk("latency_out_valid", 64'(out_valid), 64'(1));
            chk("latency_out_valid8", 64'(out_valid8), 64'(1));
        end
    endtask

    // Reference: psum = inpsum + sum(w[t]*a[t]) in wide arithmetic, truncated on compare.
    task automatic run_window(input int a[3], input logic [31:0] ip);
        longint s;
        exp_t   e;
        s = longint'($signed(ip));
        for (int t = 0; t < 3; t++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            wt_valid  = 1'($urandom_range(0, 1));
            wt_data   = 2'($urandom);
            wt_reload = (t == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_act(a[t], (t == 0) ? ip : $urandom, t == 2);
            s += longint'(kw[t] * a[t]);
            if (a[t] == 0) zeros++;
        end
        wt_valid  = 0;
        wt_reload = 0;
        e.p = s[31:0];
        e.z = zeros;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((out_valid || sb.size() != 0) && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (out_valid || sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got pending %0d expected 0", sb.size());
        end
    endtask

    // Reload request at tap 0 must win over a simultaneous activation.
    task automatic reload(input int w[3]);
        wait_drain();
        wt_reload = 1;
        act_valid = 1;
        act_data  = 2'd1;
        @(negedge clk);
        chk("reload_act_ready", 64'(act_ready), 64'(0));
        chk("reload_act_ready8", 64'(act_ready8), 64'(0));
        @(posedge clk);
        #1;
        wt_reload = 0;
        act_valid = 0;
        chk("reload_wt_ready", 64'(wt_ready), 64'(1));
        chk("reload_act_ready_load", 64'(act_ready), 64'(0));
        load_kernel(w);
    endtask

    initial begin
        int w[3];
        int a[3];
        wt_valid = 0; wt_reload = 0; act_valid = 0;
        wt_data = 0; act_data = 0; inpsum = 0;
        reset = 1;
        do_reset();

        // Basic MAC and all-zero window.
        w = '{1, -2, 1};
        load_kernel(w);
        a = '{1, 1, -1};
        run_window(a, 32'd10);
        a = '{0, 0, 0};
        run_window(a, 32'd5);

        // Backpressure in DRAIN.
        wait_drain();
        hold = 1;
        out_ready = 0;
        a = '{-2, 1, 0};
        run_window(a, 32'hFFFF_FFF0);
        repeat (4) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_outpsum", 64'(outpsum), 64'(sb[0].p));
            chk("bp_act_ready", 64'(act_ready), 64'(0));
            chk("bp_wt_ready", 64'(wt_ready), 64'(0));
        end
        hold = 0;

        // Reload beats activation, then new kernel.
        w = '{-1, -1, -1};
        reload(w);
        a = '{1, 1, 1};
        run_window(a, 32'd0);

        // Wrap in the 8-bit instance and counter saturation in the 2-bit instance.
        wait_drain();
        do_reset();
        w = '{1, 1, 1};
        load_kernel(w);
        a = '{1, 1, 1};
        run_window(a, 32'd126);
        a = '{0, 0, 0};
        run_window(a, 32'd0);
        a = '{0, 0, 1};
        run_window(a, 32'd0);

        // Reset mid-window discards the partial result and the kernel.
        wait_drain();
        send_act(1, 32'd77, 0);
        send_act(-1, 32'd0, 0);
        do_reset();
        w = '{-2, 1, -1};
        load_kernel(w);
        a = '{1, -2, 1};
        run_window(a, 32'd1000);

        // Randomized windows with occasional kernel reloads.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int t = 0; t < 3; t++) w[t] = int'($urandom_range(0, 3)) - 2;
                reload(w);
            end
            for (int t = 0; t < 3; t++) a[t] = int'($urandom_range(0, 3)) - 2;
            run_window(a, $urandom);
        end

        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
